adc_capture_ctrl: RTL and testbench

//  Downstream of the three vco_adc sinc3 decimators. Selects one channel and streams
//  its data_valid-qualified words into the four 32x512 SRAM macros on their write port.
//  The four macros act as one 2048-word linear buffer. Supports one-shot and continuous
//  (ring) capture and reports progress to the wishbone register block.

---
 rtl/adc_capture_ctrl.sv | 163 ++++++++++++++++
 tb/tb_adc_capture_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture_ctrl.sv
// Capture controller: streams one sinc3 decimator channel into a banked
// SRAM buffer in one-shot or ring mode, with settling-sample discard.
module adc_capture_ctrl #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 9,
    parameter int NUM_BANKS      = 4,
    parameter int SETTLE_SAMPLES = 2
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   start_i,
    input  logic                   stop_i,
    input  logic                   continuous_i,
    input  logic [1:0]             chan_sel_i,
    input  logic [ADDR_W+$clog2(NUM_BANKS)-1:0] capture_len_i,
    input  logic [2:0]             adc_dvalid_i,
    input  logic [DATA_W-1:0]      adc0_dat_i,
    input  logic [DATA_W-1:0]      adc1_dat_i,
    input  logic [DATA_W-1:0]      adc2_dat_i,
    output logic [NUM_BANKS-1:0]   mem_wenb_o,
    output logic [ADDR_W-1:0]      mem_waddr_o,
    output logic [DATA_W-1:0]      mem_data_o,
    output logic [DATA_W/8-1:0]    wmask_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   wrapped_o,
    output logic [ADDR_W+$clog2(NUM_BANKS)-1:0] wr_ptr_o
);

    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int PTR_W  = ADDR_W + BANK_W;
    localparam int SKIP_W = $clog2(SETTLE_SAMPLES + 2);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t              state;
    logic                cont_q;
    logic [1:0]          chan_q;
    logic [PTR_W-1:0]    last_q;
    logic [PTR_W-1:0]    ptr_q;
    logic [SKIP_W-1:0]   skip_q;

    logic                sel_vld;
    logic [DATA_W-1:0]   sel_dat;
    logic [NUM_BANKS-1:0] bank_sel_n;
    logic                start_ok;
    logic                wr_fire;
    logic                last_word;
    logic [1:0]          chan_norm;
    logic [PTR_W-1:0]    ptr_nxt;
    state_t              start_state;

    always_comb begin
        sel_vld = adc_dvalid_i[0];
        sel_dat = adc0_dat_i;
        case (chan_q)
            2'd1: begin
                sel_vld = adc_dvalid_i[1];
                sel_dat = adc1_dat_i;
            end
            2'd2: begin
                sel_vld = adc_dvalid_i[2];
                sel_dat = adc2_dat_i;
            end
            default: begin
                sel_vld = adc_dvalid_i[0];
                sel_dat = adc0_dat_i;
            end
        endcase
    end

    always_comb begin
        bank_sel_n = '1;
        bank_sel_n[ptr_q[PTR_W-1:ADDR_W]] = 1'b0;
    end

    // Channel 3 does not exist and aliases to channel 0.
    assign chan_norm   = (chan_sel_i == 2'd3) ? 2'd0 : chan_sel_i;
    assign start_ok    = start_i && (state == IDLE || state == DONE);
    assign wr_fire     = (state == CAPTURE) && sel_vld;
    assign last_word   = wr_fire && !cont_q && (ptr_q == last_q);
    assign ptr_nxt     = ptr_q + 1'b1;
    assign start_state = (SETTLE_SAMPLES == 0) ? CAPTURE : SETTLE;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state       <= IDLE;
            cont_q      <= 1'b0;
            chan_q      <= 2'd0;
            last_q      <= '0;
            ptr_q       <= '0;
            skip_q      <= '0;
            mem_wenb_o  <= '1;
            mem_waddr_o <= '0;
            mem_data_o  <= '0;
            wmask_o     <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            wrapped_o   <= 1'b0;
            wr_ptr_o    <= '0;
        end else begin
            mem_wenb_o <= '1;
            wmask_o    <= '0;

            if (wr_fire) begin
                mem_wenb_o  <= bank_sel_n;
                mem_waddr_o <= ptr_q[ADDR_W-1:0];
                mem_data_o  <= sel_dat;
                wmask_o     <= '1;
                ptr_q       <= ptr_nxt;
                wr_ptr_o    <= ptr_nxt;
                if (cont_q && (ptr_q == '1)) begin
                    wrapped_o <= 1'b1;
                end
            end

            case (state)
                IDLE, DONE: begin
                    if (start_ok) begin
                        cont_q    <= continuous_i;
                        chan_q    <= chan_norm;
                        // A zero length wraps to the last index of the full buffer.
                        last_q    <= capture_len_i - 1'b1;
                        ptr_q     <= '0;
                        wr_ptr_o  <= '0;
                        skip_q    <= '0;
                        done_o    <= 1'b0;
                        wrapped_o <= 1'b0;
                        busy_o    <= 1'b1;
                        state     <= start_state;
                    end
                end
                SETTLE: begin
                    if (stop_i) begin
                        state  <= DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end else if (sel_vld) begin
                        if (skip_q == SKIP_W'(SETTLE_SAMPLES - 1)) begin
                            state <= CAPTURE;
                        end else begin
                            skip_q <= skip_q + 1'b1;
                        end
                    end
                end
                CAPTURE: begin
                    if (stop_i || last_word) begin
                        state  <= DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Randomized bench for adc_capture_ctrl with an in-bench behavioural
// model of the capture buffer compared against the DUT every cycle.
module tb_adc_capture_ctrl;

    localparam int SETTLE = 2;
    localparam int DEPTH  = 2048;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        cont = 1'b0;
    logic [1:0]  chsel = 2'd0;
    logic [10:0] clen = 11'd0;
    logic [2:0]  dv = 3'd0;
    logic [31:0] d0 = 32'd0;
    logic [31:0] d1 = 32'd0;
    logic [31:0] d2 = 32'd0;

    logic [3:0]  mem_wenb;
    logic [8:0]  mem_waddr;
    logic [31:0] mem_data;
    logic [3:0]  wmask;
    logic        busy;
    logic        done;
    logic        wrapped;
    logic [10:0] wr_ptr;

    adc_capture_ctrl dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .start_i       (start),
        .stop_i        (stop),
        .continuous_i  (cont),
        .chan_sel_i    (chsel),
        .capture_len_i (clen),
        .adc_dvalid_i  (dv),
        .adc0_dat_i    (d0),
        .adc1_dat_i    (d1),
        .adc2_dat_i    (d2),
        .mem_wenb_o    (mem_wenb),
        .mem_waddr_o   (mem_waddr),
        .mem_data_o    (mem_data),
        .wmask_o       (wmask),
        .busy_o        (busy),
        .done_o        (done),
        .wrapped_o     (wrapped),
        .wr_ptr_o      (wr_ptr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Behavioural model: a capture is a run of sample indices into a
    // linear 2048-word buffer; bank/address follow by division.
    bit          m_active = 0;
    bit          m_ring = 0;
    int          m_ch = 0;
    int          m_skip = 0;
    int          m_count = 0;
    int          m_len = 0;
    int          m_idx = 0;
    logic        m_v;
    logic [31:0] m_s;
    logic [3:0]  e_wenb = 4'hF;
    logic [8:0]  e_waddr = 9'd0;
    logic [31:0] e_data = 32'd0;
    logic [3:0]  e_wmask = 4'h0;
    bit          e_busy = 0;
    bit          e_done = 0;
    bit          e_wrapped = 0;
    int          e_wrptr = 0;
    logic [31:0] model_mem [DEPTH];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active  = 0;
            m_skip    = 0;
            m_count   = 0;
            e_wenb    = 4'hF;
            e_waddr   = 9'd0;
            e_data    = 32'd0;
            e_wmask   = 4'h0;
            e_busy    = 0;
            e_done    = 0;
            e_wrapped = 0;
            e_wrptr   = 0;
        end else begin
            e_wenb  = 4'hF;
            e_wmask = 4'h0;
            m_v = dv[m_ch];
            m_s = (m_ch == 0) ? d0 : (m_ch == 1) ? d1 : d2;
            if (!m_active) begin
                if (start) begin
                    m_active  = 1;
                    m_ring    = cont;
                    m_ch      = (chsel == 2'd3) ? 0 : int'(chsel);
                    m_len     = (clen == 0) ? DEPTH : int'(clen);
                    m_skip    = SETTLE;
                    m_count   = 0;
                    e_done    = 0;
                    e_wrapped = 0;
                    e_wrptr   = 0;
                end
            end else begin
                if (m_skip == 0 && m_v) begin
                    m_idx   = m_count % DEPTH;
                    e_wenb  = ~(4'b0001 << (m_idx / 512));
                    e_waddr = 9'(m_idx % 512);
                    e_data  = m_s;
                    e_wmask = 4'hF;
                    model_mem[m_idx] = m_s;
                    m_count++;
                    e_wrptr = m_count % DEPTH;
                    if (m_ring && (m_count % DEPTH) == 0) e_wrapped = 1;
                    if (!m_ring && m_count == m_len) begin
                        m_active = 0;
                        e_done   = 1;
                    end
                end else if (m_v && m_skip > 0) begin
                    m_skip--;
                end
                if (stop) begin
                    m_active = 0;
                    e_done   = 1;
                end
            end
            e_busy = m_active;
        end
    end

    logic [31:0] dut_mem [DEPTH];
    int          dut_wr = 0;
    int          last_bank = 0;
    int          last_addr = 0;

    always @(negedge clk) begin
        if (!rst) begin
            chk("wenb", 32'(mem_wenb), 32'(e_wenb));
            chk("wmask", 32'(wmask), 32'(e_wmask));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("done", 32'(done), 32'(e_done));
            chk("wrapped", 32'(wrapped), 32'(e_wrapped));
            chk("wr_ptr", 32'(wr_ptr), 32'(e_wrptr));
            chk("waddr", 32'(mem_waddr), 32'(e_waddr));
            chk("wdata", mem_data, e_data);
            if (wmask == 4'hF) begin
                dut_wr++;
                for (int b = 0; b < 4; b++) begin
                    if (!mem_wenb[b]) begin
                        dut_mem[b * 512 + int'(mem_waddr)] = mem_data;
                        last_bank = b;
                        last_addr = int'(mem_waddr);
                    end
                end
            end
        end
    end

    int tb_ch = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        dv    = 3'd0;
    endtask

    // One cycle: the selected channel gets (v, d); the others get noise.
    task automatic cyc(input bit v, input logic [31:0] d);
        dv = 3'($urandom_range(0, 7));
        dv[tb_ch] = v;
        d0 = $urandom;
        d1 = $urandom;
        d2 = $urandom;
        case (tb_ch)
            0: d0 = d;
            1: d1 = d;
            default: d2 = d;
        endcase
        tick();
    endtask

    task automatic do_start(input bit ring, input logic [1:0] ch,
                            input logic [10:0] len);
        cont  = ring;
        chsel = ch;
        clen  = len;
        tb_ch = (ch == 2'd3) ? 0 : int'(ch);
        start = 1'b1;
        cyc(1'b0, 32'd0);
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 2)) cyc(1'b0, 32'd0);
    endtask

    logic [31:0] sent [2100];
    int base;
    int nmis;
    int k;

    initial begin
        // Reset values
        rst = 1'b1;
        @(posedge clk);
        #2;
        chk("rst_wenb", 32'(mem_wenb), 32'hF);
        chk("rst_wmask", 32'(wmask), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_wrptr", 32'(wr_ptr), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // 1: one-shot ch1 len 4, two settle samples discarded
        base = dut_wr;
        do_start(1'b0, 2'd1, 11'd4);
        chk("t1_busy", 32'(busy), 32'h1);
        for (int i = 0; i < 6; i++) begin
            gap();
            cyc(1'b1, 32'hA0 + 32'(i));
        end
        cyc(1'b0, 32'd0);
        chk("t1_mem0", dut_mem[0], 32'hA2);
        chk("t1_mem1", dut_mem[1], 32'hA3);
        chk("t1_mem2", dut_mem[2], 32'hA4);
        chk("t1_mem3", dut_mem[3], 32'hA5);
        chk("t1_model3", model_mem[3], 32'hA5);
        chk("t1_done", 32'(done), 32'h1);
        chk("t1_busy_end", 32'(busy), 32'h0);
        chk("t1_wrptr", 32'(wr_ptr), 32'h4);
        chk("t1_writes", 32'(dut_wr - base), 32'h4);

        // 2: one-shot full buffer, dvalid every cycle
        base = dut_wr;
        do_start(1'b0, 2'd0, 11'd0);
        for (int i = 0; i < 2100 && busy; i++) cyc(1'b1, $urandom);
        chk("t2_timeout", 32'(busy), 32'h0);
        cyc(1'b0, 32'd0);
        chk("t2_writes", 32'(dut_wr - base), 32'd2048);
        chk("t2_done", 32'(done), 32'h1);
        chk("t2_last_bank", 32'(last_bank), 32'd3);
        chk("t2_last_addr", 32'(last_addr), 32'd511);
        chk("t2_wrptr", 32'(wr_ptr), 32'h0);
        nmis = 0;
        for (int i = 0; i < DEPTH; i++)
            if (dut_mem[i] !== model_mem[i]) nmis++;
        chk("t2_mem_cmp", 32'(nmis), 32'h0);

        // 3: ring mode, 2050 captured samples with random gaps
        do_start(1'b1, 2'd1, 11'd123);
        k = 0;
        for (int i = 0; i < 4000 && k < SETTLE + 2050; i++) begin
            if ($urandom_range(0, 4) != 0) begin
                if (k >= SETTLE) sent[k - SETTLE] = $urandom;
                cyc(1'b1, (k >= SETTLE) ? sent[k - SETTLE] : 32'h5E77);
                k++;
            end else begin
                cyc(1'b0, 32'd0);
            end
        end
        chk("t3_timeout", 32'(k), 32'(SETTLE + 2050));
        cyc(1'b0, 32'd0);
        chk("t3_wrapped", 32'(wrapped), 32'h1);
        chk("t3_wrptr", 32'(wr_ptr), 32'h2);
        chk("t3_mem0", dut_mem[0], sent[2048]);
        chk("t3_mem1", dut_mem[1], sent[2049]);
        chk("t3_mem2", dut_mem[2], sent[2]);
        chk("t3_busy", 32'(busy), 32'h1);
        stop = 1'b1;
        cyc(1'b0, 32'd0);
        chk("t3_done", 32'(done), 32'h1);
        chk("t3_busy_end", 32'(busy), 32'h0);

        // 4: channel 2 only, then channel 3 aliases to channel 0
        do_start(1'b0, 2'd2, 11'd5);
        for (int i = 0; i < 7; i++) begin
            gap();
            cyc(1'b1, 32'hC0 + 32'(i));
        end
        cyc(1'b0, 32'd0);
        for (int i = 0; i < 5; i++)
            chk("t4_ch2", dut_mem[i], 32'hC2 + 32'(i));
        chk("t4_done", 32'(done), 32'h1);
        do_start(1'b0, 2'd3, 11'd3);
        for (int i = 0; i < 5; i++) begin
            gap();
            cyc(1'b1, 32'hD0 + 32'(i));
        end
        cyc(1'b0, 32'd0);
        for (int i = 0; i < 3; i++)
            chk("t4_ch3", dut_mem[i], 32'hD2 + 32'(i));

        // 5: start while busy ignored; stop with coincident dvalid
        base = dut_wr;
        do_start(1'b1, 2'd0, 11'd0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'hE0 + 32'(i));
        cont  = 1'b0;
        chsel = 2'd2;
        clen  = 11'd1;
        start = 1'b1;
        cyc(1'b1, 32'hE4);
        chk("t5_busy", 32'(busy), 32'h1);
        stop  = 1'b1;
        start = 1'b1;
        cyc(1'b1, 32'hE5);
        cyc(1'b1, 32'hE6);
        chk("t5_mem3", dut_mem[3], 32'hE5);
        chk("t5_done", 32'(done), 32'h1);
        chk("t5_busy_end", 32'(busy), 32'h0);
        chk("t5_wrptr", 32'(wr_ptr), 32'h4);
        chk("t5_writes", 32'(dut_wr - base), 32'h4);
        cont  = 1'b1;
        chsel = 2'd0;
        tb_ch = 0;
        start = 1'b1;
        stop  = 1'b1;
        cyc(1'b0, 32'd0);
        chk("t5_start_wins", 32'(busy), 32'h1);
        chk("t5_done_clr", 32'(done), 32'h0);

        // 6: asynchronous reset mid-capture
        for (int i = 0; i < 7; i++) cyc(1'b1, $urandom);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_wenb", 32'(mem_wenb), 32'hF);
        chk("t6_wmask", 32'(wmask), 32'h0);
        chk("t6_waddr", 32'(mem_waddr), 32'h0);
        chk("t6_data", mem_data, 32'h0);
        chk("t6_busy", 32'(busy), 32'h0);
        chk("t6_done", 32'(done), 32'h0);
        chk("t6_wrapped", 32'(wrapped), 32'h0);
        chk("t6_wrptr", 32'(wr_ptr), 32'h0);
        tick();
        tick();
        rst  = 1'b0;
        base = dut_wr;
        for (int i = 0; i < 5; i++) cyc(1'b1, $urandom);
        chk("t6_no_write", 32'(dut_wr - base), 32'h0);
        chk("t6_idle", 32'(busy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
